// File: rtl/node_injection_scheduler.sv
// Injection arbiter sharing one network port among backward ants, periodic forward ants and data.
// Define NODE_INJ_STATS_EN to build the four statistics counters; otherwise the stat ports read 0.

`ifndef X_NODES
`define X_NODES 4
`endif
`ifndef Y_NODES
`define Y_NODES 4
`endif
`ifndef NODES
`define NODES (`X_NODES*`Y_NODES)
`endif

package node_inj_pkg;
    localparam int XW = (`X_NODES > 1) ? $clog2(`X_NODES) : 1;
    localparam int YW = (`Y_NODES > 1) ? $clog2(`Y_NODES) : 1;

    typedef struct packed {
        logic [XW-1:0] x_source;
        logic [YW-1:0] y_source;
        logic [XW-1:0] x_dest;
        logic [YW-1:0] y_dest;
        logic          ant;
        logic          backward;
        logic [XW-1:0] x_memory;
        logic [YW-1:0] y_memory;
        logic [3:0]    num_memories;
        logic [15:0]   payload;
    } packet_t;
endpackage

module node_injection_scheduler
    import node_inj_pkg::*;
#(
    parameter int X_LOC           = 0,
    parameter int Y_LOC           = 0,
    parameter int ANT_PERIOD      = 100,
    parameter int ANT_BACKLOG_MAX = 4,
    parameter int DATA_STARVE_LIM = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ant_en,
    input  packet_t     bwd_data,
    input  logic        bwd_val,
    output logic        bwd_ready,
    input  packet_t     dat_data,
    input  logic        dat_val,
    output logic        dat_ready,
    input  logic        net_en,
    output packet_t     net_data,
    output logic        net_val,
    output logic [31:0] stat_dat_cnt,
    output logic [31:0] stat_fwd_cnt,
    output logic [31:0] stat_bwd_cnt,
    output logic [31:0] stat_drop_cnt
);

    localparam int NODES = `NODES;
    localparam int SELF  = Y_LOC * `X_NODES + X_LOC;
    localparam int RW    = (NODES > 1) ? $clog2(NODES) : 1;
    localparam int PW    = $clog2(ANT_PERIOD);
    localparam int BW    = $clog2(ANT_BACKLOG_MAX + 1);
    localparam int SW    = $clog2(DATA_STARVE_LIM + 1);

    localparam logic [PW-1:0] PER_LAST    = PW'(ANT_PERIOD - 1);
    localparam logic [BW-1:0] BACKLOG_MAX = BW'(ANT_BACKLOG_MAX);
    localparam logic [SW-1:0] STARVE_LIM  = SW'(DATA_STARVE_LIM);
    localparam logic [RW-1:0] RR_SELF     = RW'(SELF);
    localparam logic [RW-1:0] RR_LAST     = RW'(NODES - 1);
    localparam logic [RW-1:0] RR_INIT     = RW'((SELF + 1) % NODES);

    logic [PW-1:0] per_cnt;
    logic [BW-1:0] backlog;
    logic [SW-1:0] starve;
    logic [RW-1:0] rr_idx;
    logic [RW-1:0] rr_plus1;
    logic [RW-1:0] rr_next;
    logic          tick;
    logic          force_dat;
    logic          grant_bwd;
    logic          grant_fwd;
    logic          grant_dat;
    logic          grant_any;
    packet_t       src_pkt;
    packet_t       fwd_pkt;
    packet_t       dat_pkt;

    always_comb begin
        tick      = (per_cnt == PER_LAST) && ant_en;
        force_dat = dat_val && (starve >= STARVE_LIM);
        grant_bwd = net_en && bwd_val && !force_dat;
        grant_fwd = net_en && !force_dat && !bwd_val && (backlog != '0);
        grant_dat = net_en && dat_val && (force_dat || (!bwd_val && (backlog == '0)));
        grant_any = grant_bwd || grant_fwd || grant_dat;

        // Round-robin destination skips our own node so an ant never targets itself.
        rr_plus1 = (rr_idx == RR_LAST) ? '0 : rr_idx + 1'b1;
        rr_next  = rr_plus1;
        if (rr_plus1 == RR_SELF) begin
            rr_next = (rr_plus1 == RR_LAST) ? '0 : rr_plus1 + 1'b1;
        end

        src_pkt          = '0;
        src_pkt.x_source = XW'(X_LOC);
        src_pkt.y_source = YW'(Y_LOC);

        fwd_pkt        = src_pkt;
        fwd_pkt.x_dest = XW'(int'(rr_idx) % `X_NODES);
        fwd_pkt.y_dest = YW'(int'(rr_idx) / `X_NODES);
        fwd_pkt.ant    = 1'b1;

        dat_pkt     = dat_data;
        dat_pkt.ant = 1'b0;
    end

    assign bwd_ready = grant_bwd;
    assign dat_ready = grant_dat;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            per_cnt  <= '0;
            backlog  <= '0;
            starve   <= '0;
            rr_idx   <= RR_INIT;
            net_val  <= 1'b0;
            net_data <= src_pkt;
        end else begin
            per_cnt <= (per_cnt == PER_LAST) ? '0 : per_cnt + 1'b1;

            // A tick coinciding with a forward grant leaves the credit count unchanged.
            if (tick && !grant_fwd && (backlog != BACKLOG_MAX)) begin
                backlog <= backlog + 1'b1;
            end else if (grant_fwd && !tick) begin
                backlog <= backlog - 1'b1;
            end

            if (net_en) begin
                if (!dat_val || grant_dat) begin
                    starve <= '0;
                end else if (starve != STARVE_LIM) begin
                    starve <= starve + 1'b1;
                end
            end

            if (grant_fwd) begin
                rr_idx <= rr_next;
            end

            net_val <= grant_any;
            if (grant_bwd) begin
                net_data <= bwd_data;
            end else if (grant_fwd) begin
                net_data <= fwd_pkt;
            end else if (grant_dat) begin
                net_data <= dat_pkt;
            end
        end
    end

`ifdef NODE_INJ_STATS_EN
    logic [31:0] dat_cnt;
    logic [31:0] fwd_cnt;
    logic [31:0] bwd_cnt;
    logic [31:0] drop_cnt;
    logic        drop;

    assign drop = tick && !grant_fwd && (backlog == BACKLOG_MAX);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            dat_cnt  <= '0;
            fwd_cnt  <= '0;
            bwd_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            if (grant_dat) dat_cnt <= dat_cnt + 32'd1;
            if (grant_fwd) fwd_cnt <= fwd_cnt + 32'd1;
            if (grant_bwd) bwd_cnt <= bwd_cnt + 32'd1;
            if (drop)      drop_cnt <= drop_cnt + 32'd1;
        end
    end

    assign stat_dat_cnt  = dat_cnt;
    assign stat_fwd_cnt  = fwd_cnt;
    assign stat_bwd_cnt  = bwd_cnt;
    assign stat_drop_cnt = drop_cnt;
`else
    assign stat_dat_cnt  = '0;
    assign stat_fwd_cnt  = '0;
    assign stat_bwd_cnt  = '0;
    assign stat_drop_cnt = '0;
`endif

endmodule
